// File: rtl/corrige_hamming.sv
// Hamming(15,11) single-error-correcting decoder: two-stage valid/ready pipeline
// (syndrome, then correction) with saturating delivered/corrected word counters.
module corrige_hamming #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [14:0]      entrada,
  input  logic             entrada_valida,
  output logic             entrada_pronta,
  output logic [10:0]      saida,
  output logic             saida_valida,
  input  logic             saida_pronta,
  output logic             erro_corrigido,
  output logic [3:0]       sindrome,
  input  logic             limpa_contadores,
  output logic [CNT_W-1:0] contador_palavras,
  output logic [CNT_W-1:0] contador_corrigidas
);

  logic             r_v1;
  logic [10:0]      r_d1;
  logic [3:0]       r_s1;
  logic             r_v2;
  logic [10:0]      r_saida;
  logic             r_erro;
  logic [3:0]       r_sind;
  logic [CNT_W-1:0] r_cnt_pal;
  logic [CNT_W-1:0] r_cnt_cor;

  logic        w_avanca1;
  logic        w_avanca2;
  logic        w_xfer_out;
  logic [3:0]  w_sind;
  logic [10:0] w_dados_in;
  logic [10:0] w_dados_corr;

  // Hamming position (1..15) of data bit j.
  function automatic logic [3:0] posicao(input int unsigned j);
    case (j)
      0:       posicao = 4'd3;
      1:       posicao = 4'd5;
      2:       posicao = 4'd6;
      3:       posicao = 4'd7;
      default: posicao = 4'(j + 5);
    endcase
  endfunction

  assign w_avanca2      = !r_v2 || saida_pronta;
  assign w_avanca1      = !r_v1 || w_avanca2;
  assign w_xfer_out     = r_v2 && saida_pronta;
  assign entrada_pronta = w_avanca1;

  assign w_dados_in = {entrada[14:8], entrada[6:4], entrada[2]};

  always_comb begin
    w_sind = '0;
    for (int unsigned i = 0; i < 15; i++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if ((((i + 1) >> k) & 32'd1) != 32'd0) begin
          w_sind[k] = w_sind[k] ^ entrada[i];
        end
      end
    end
  end

  // Only data bits are carried past stage 1; a syndrome naming a parity
  // position therefore leaves the data untouched.
  always_comb begin
    w_dados_corr = r_d1;
    for (int unsigned j = 0; j < 11; j++) begin
      if (r_s1 == posicao(j)) begin
        w_dados_corr[j] = ~r_d1[j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
      r_s1 <= '0;
    end else if (w_avanca1) begin
      r_v1 <= entrada_valida;
      if (entrada_valida) begin
        r_d1 <= w_dados_in;
        r_s1 <= w_sind;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r_saida <= '0;
      r_erro  <= 1'b0;
      r_sind  <= '0;
    end else if (w_avanca2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_saida <= w_dados_corr;
        r_erro  <= (r_s1 != 4'd0);
        r_sind  <= r_s1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_pal <= '0;
      r_cnt_cor <= '0;
    end else if (limpa_contadores) begin
      r_cnt_pal <= '0;
      r_cnt_cor <= '0;
    end else if (w_xfer_out) begin
      if (r_cnt_pal != '1) begin
        r_cnt_pal <= r_cnt_pal + CNT_W'(1);
      end
      if (r_erro && (r_cnt_cor != '1)) begin
        r_cnt_cor <= r_cnt_cor + CNT_W'(1);
      end
    end
  end

  assign saida               = r_saida;
  assign saida_valida        = r_v2;
  assign erro_corrigido      = r_erro;
  assign sindrome            = r_sind;
  assign contador_palavras   = r_cnt_pal;
  assign contador_corrigidas = r_cnt_cor;

endmodule
